// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, with valid/ready on both sides.
// Optional signed overflow output under SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int RES_W = WIDTH - 1;

  sub_state_e       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [RES_W-1:0] res_r;
  logic [CNT_W-1:0] cnt_r;
  logic             br_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             d_s;
  logic             bo_s;
  logic             last_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_r;
`endif

  full_subtractor u_fs (
    .x  (a_sh_r[0]),
    .y  (b_sh_r[0]),
    .bi (br_r),
    .d  (d_s),
    .bo (bo_s)
  );

  assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Handshake FSM, operand shifting and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      res_r       <= {RES_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      br_r        <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      diff_r      <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            br_r       <= bin;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          // Drop the oldest kept bit; the final d_s completes the word.
          res_r  <= RES_W'({d_s, res_r} >> 1);
          br_r   <= bo_s;
          if (last_s) begin
            diff_r      <= {d_s, res_r};
            bout_r      <= bo_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_r       <= br_r ^ bo_s;
`endif
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): table vectors,
// corner sequences and random operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = 8'h00;
  logic [W-1:0] b = 8'h00;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                       output logic [7:0] md, output logic mbo, output logic mov);
    int ua, ub, ui, sa, sb, sr;
    ua = ma; ub = mb; ui = mbin;
    sa = $signed(ma); sb = $signed(mb);
    md  = 8'(ua - ub - ui);
    mbo = (ua < ub + ui);
    sr  = sa - sb - ui;
    mov = (sr < -128) || (sr > 127);
  endtask

  // Called at a negedge: present operands, let one edge accept them.
  task automatic start_op(input logic [7:0] xa, input logic [7:0] xb, input logic xbin);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A; bin = 1'b1;
    chk("in_ready_in_run", in_ready, 0);
  endtask

  task automatic wait_result(input string name, input logic [7:0] ed, input logic ebo, input logic eov);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, W);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_bout"}, bout, ebo);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk({name, "_ovf"}, ovf, eov);
`else
    if (eov === 1'bx) chk({name, "_ovf_x"}, 0, 1);
`endif
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_out_valid_drop"}, out_valid, 0);
    chk({name, "_in_ready_back"}, in_ready, 1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] md;
    logic       mbo, mov;
    logic [7:0] ra, rb;
    logic       rbin;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Table vectors.
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: outputs stable, new operands refused until handshake.
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_result("bp", 8'h1E, 1'b0, 1'b0);
    a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_diff_held", diff, 8'h1E);
      chk("bp_bout_held", bout, 0);
      chk("bp_in_ready_low", in_ready, 0);
    end
    handshake("bp");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_taken", in_ready, 0);
    wait_result("bp_new", 8'h22, 1'b0, 1'b0);
    handshake("bp_new");

    // Reset during the third RUN cycle.
    start_op(8'h01, 8'h02, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready_back", in_ready, 1);
    repeat (12) @(negedge clk);
    chk("midrst_no_stale_valid", out_valid, 0);
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_result("after_rst", 8'h1E, 1'b0, 1'b0);
    handshake("after_rst");

    // Random operands, random idle gaps and out_ready delays.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(ra, rb, rbin, md, mbo, mov);
      start_op(ra, rb, rbin);
      wait_result($sformatf("rnd%0d", n), md, mbo, mov);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rnd_hold_diff", diff, md);
      handshake($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b - bin` one bit per clock, LSB first. It is the inverse-operation companion to the team's full-adder datapath. A full-subtractor cell is reused across `WIDTH` cycles, so area is traded for latency. Operands enter and results leave through independent valid/ready handshakes, so the block drops into streaming arithmetic pipelines.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width. Legal range is `WIDTH >= 2`.

Ports:
- `clk` (in, 1): single clock; all logic is on the rising edge.
- `rst` (in, 1): synchronous, active-high reset.
- `in_valid` (in, 1): operand valid.
- `in_ready` (out, 1): block can accept operands.
- `a` (in, `WIDTH`): minuend.
- `b` (in, `WIDTH`): subtrahend.
- `bin` (in, 1): borrow-in.
- `out_valid` (out, 1): result valid.
- `out_ready` (in, 1): downstream accepts the result.
- `diff` (out, `WIDTH`): `a - b - bin` modulo 2^`WIDTH`.
- `bout` (out, 1): unsigned borrow-out; 1 when `a < b + bin`.
- `ovf` (out, 1): signed overflow. Present only under the macro described in Configuration.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `in_ready = 1`.
  - On an edge with `in_valid & in_ready`: latch `a` and `b` into shift registers, set borrow flop to `bin`, clear bit counter, go to `RUN`.
  - `in_valid` alone while not ready is ignored. Operands are sampled only at the accepting edge.
- `RUN`:
  - Each edge, apply the full-subtractor to the operand shift-register LSBs and the borrow flop:
    - `d = x ^ y ^ br`
    - `br' = (~x & y) | (~(x ^ y) & br)`
  - Shift `d` into the result register from the MSB side, so after `WIDTH` shifts bit 0 is the first bit computed.
  - Update the borrow flop and increment the counter.
  - On the edge where counter == `WIDTH-1`, go to `DONE`.
- `DONE`:
  - `out_valid = 1`. `diff`, `bout` and `ovf` are held stable.
  - On an edge with `out_valid & out_ready`, go to `IDLE`.
- No overlap between operations: `in_ready = 0` in `RUN` and `DONE`, including the cycle of the output handshake.
- Counter width is `$clog2(WIDTH)` and it never wraps. `WIDTH` is not required to be a power of two.
- `diff` and `bout` are registered outputs. In `IDLE` and `RUN` they hold their previous values; only `out_valid` qualifies them.

## Timing
- Reset values: state `IDLE`, `in_ready = 0` while `rst` is high and 1 from the first cycle after deassertion, `out_valid = 0`, `diff = 0`, `bout = 0`, `ovf = 0`, counter 0, borrow flop 0.
- Latency: `out_valid` rises exactly `WIDTH` edges after the accepting edge.
- Throughput: at most one operation per `WIDTH + 2` cycles with `out_ready` held high:
  - `WIDTH` cycles in `RUN`;
  - 1 cycle in `DONE` for the output handshake;
  - 1 cycle in `IDLE` for the input handshake.
- Backpressure: `DONE` persists indefinitely while `out_ready = 0`. Outputs must not change.
- `out_ready` is ignored outside `DONE`.
- Reset has priority over everything, including mid-`RUN` and a `DONE` handshake on the same edge. The partial result is discarded and the block returns to reset values.

## Configuration
- Macro: `SERIAL_SUB_SIGNED_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - A flop captures the borrow into the MSB, i.e. the borrow flop value at the start of the final `RUN` cycle.
  - `ovf = borrow_into_msb ^ bout`, valid with `out_valid`.
  - `ovf` resets to 0.
- Undefined: port `ovf` and its flop are absent. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_e` (`IDLE`, `RUN`, `DONE`);
  - function `cnt_w(width)` returning `$clog2(width)`.
- Sub-module `full_subtractor`: purely combinational. Inputs `x`, `y`, `bi`; outputs `d` and `bo` per the equations above. Instantiated once in `serial_subtractor`.
- All state, shift registers and handshake logic live in `serial_subtractor`.

## Test plan
All scenarios use `WIDTH = 8`.
1. Basic: `a = 0x5A`, `b = 0x3C`, `bin = 0` -> `diff = 0x1E`, `bout = 0`, `out_valid` asserted exactly 8 edges after the accepting edge.
2. Wrap-around: `a = 0x00`, `b = 0x01`, `bin = 0` -> `diff = 0xFF`, `bout = 1`, `ovf = 0`.
3. Signed overflow, macro defined: `a = 0x80`, `b = 0x01` -> `diff = 0x7F`, `bout = 0`, `ovf = 1`. Also `a = 0x7F`, `b = 0xFF` -> `diff = 0x80`, `ovf = 1`.
4. Borrow-in: `a = 0x10`, `b = 0x0F`, `bin = 1` -> `diff = 0x00`, `bout = 0`.
5. Backpressure: hold `out_ready = 0` for 5 cycles in `DONE` while driving `in_valid = 1` with new operands. Required: `diff`/`bout` stable, `in_ready = 0`, new operands not taken. Raise `out_ready`: handshake occurs, `in_ready` returns 1 on the next cycle, and the new operands are accepted then.
6. Reset mid-operation: assert `rst` on the 3rd `RUN` cycle -> next cycle `out_valid = 0`, `diff = 0`, `in_ready = 0`. After deassertion, `in_ready = 1`, and the subsequent op `0x5A - 0x3C` yields `0x1E`.
